// File: rtl/noc_out_port_ctrl_pkg.sv
// noc_out_port_ctrl_pkg: shared NoC flit width, flit-type encodings and output-port FSM states
package noc_out_port_ctrl_pkg;
    localparam int NOC_FLIT_W = 34;
    localparam logic [1:0] FT_BODY      = 2'b00;
    localparam logic [1:0] FT_HEAD      = 2'b01;
    localparam logic [1:0] FT_TAIL      = 2'b10;
    localparam logic [1:0] FT_HEAD_TAIL = 2'b11;
    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;
endpackage

// File: rtl/noc_out_reg.sv
// noc_out_reg: single valid/ready output register stage, one flit per cycle throughput
module noc_out_reg #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         stage_free
);
    assign stage_free = !valid || ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= din;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/noc_out_port_ctrl.sv
// noc_out_port_ctrl: wormhole output-port lock for two inputs, external fixed-priority arbiter
module noc_out_port_ctrl
    import noc_out_port_ctrl_pkg::*;
#(
    parameter int FLIT_W = NOC_FLIT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             in_valid_i,
    input  logic [1:0][FLIT_W-1:0] in_flit_i,
    output logic [1:0]             in_ready_o,
    output logic [1:0]             req_o,
    input  logic [1:0]             grant_i,
    output logic                   out_valid_o,
    output logic [FLIT_W-1:0]      out_flit_o,
    input  logic                   out_ready_i,
    output logic                   busy_o,
    output logic                   err_o
);
    state_t state, state_nx;
    logic owner, owner_nx, err_nx;
    logic stage_free, acc, sel, gnt_ok;
    logic [1:0] is_head, acc_ty;
    logic [FLIT_W-1:0] acc_flit;
    assign is_head[0] = in_flit_i[0][FLIT_W-1 -: 2] == FT_HEAD || in_flit_i[0][FLIT_W-1 -: 2] == FT_HEAD_TAIL;
    assign is_head[1] = in_flit_i[1][FLIT_W-1 -: 2] == FT_HEAD || in_flit_i[1][FLIT_W-1 -: 2] == FT_HEAD_TAIL;
    assign acc      = |(in_ready_o & in_valid_i);
    assign sel      = in_ready_o[1];
    assign acc_flit = in_flit_i[sel];
    assign acc_ty   = acc_flit[FLIT_W-1 -: 2];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            owner <= 1'b0;
            err_o <= 1'b0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            err_o <= err_nx;
        end
    end
    always_comb begin
        state_nx = !acc ? state :
                   state == S_IDLE ? (acc_ty == FT_HEAD ? S_LOCKED : S_IDLE) :
                   (acc_ty == FT_TAIL ? S_IDLE : S_LOCKED);
        owner_nx = (acc && state == S_IDLE && acc_ty == FT_HEAD) ? sel : owner;
        err_nx   = err_o || (acc && state == S_LOCKED && (acc_ty == FT_HEAD || acc_ty == FT_HEAD_TAIL));
    end
    // A malformed grant (zero, multi-hot, or pointing at a non-requester) accepts nothing
    always_comb begin
        req_o      = (!rst && state == S_IDLE) ? (in_valid_i & is_head) : 2'b00;
        gnt_ok     = $onehot(grant_i) && |(grant_i & req_o);
        in_ready_o = rst ? 2'b00 :
                     state == S_IDLE ? ((gnt_ok && stage_free) ? grant_i : 2'b00) :
                     (stage_free ? (owner ? 2'b10 : 2'b01) : 2'b00);
        busy_o     = state == S_LOCKED;
    end
    noc_out_reg #(.W(FLIT_W)) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (acc),
        .din       (acc_flit),
        .ready     (out_ready_i),
        .valid     (out_valid_o),
        .data      (out_flit_o),
        .stage_free(stage_free)
    );
endmodule

// File: tb/tb_noc_out_port_ctrl.sv
// tb_noc_out_port_ctrl: directed checks of reset, locking, contention, backpressure, errors
module tb_noc_out_port_ctrl;
    localparam int W = 34;
    logic clk = 1'b0;
    logic rst;
    logic [1:0] in_valid_i, in_ready_o, req_o, grant_i;
    logic [1:0][W-1:0] in_flit_i;
    logic out_valid_o, out_ready_i, busy_o, err_o;
    logic [W-1:0] out_flit_o;
    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    noc_out_port_ctrl #(.FLIT_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid_i),
        .in_flit_i  (in_flit_i),
        .in_ready_o (in_ready_o),
        .req_o      (req_o),
        .grant_i    (grant_i),
        .out_valid_o(out_valid_o),
        .out_flit_o (out_flit_o),
        .out_ready_i(out_ready_i),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    function automatic logic [W-1:0] fl(input logic [1:0] ty, input logic [31:0] p);
        return {ty, p};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid_i = 2'b11;
        in_flit_i[0] = fl(2'b01, 32'h0);
        in_flit_i[1] = fl(2'b01, 32'h1);
        grant_i = 2'b01;
        out_ready_i = 1'b1;
        settle();
        chk("rst_req", req_o, 2'b00);
        chk("rst_rdy", in_ready_o, 2'b00);
        tick();
        tick();
        chk("rst_vld", out_valid_o, 0);
        chk("rst_flit", out_flit_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        rst = 1'b0;
        in_valid_i = 2'b00;
        settle();
        chk("idle_req", req_o, 2'b00);

        // single packet on input 1
        in_valid_i = 2'b10;
        in_flit_i[1] = fl(2'b01, 32'hA1);
        grant_i = 2'b10;
        settle();
        chk("a_req", req_o, 2'b10);
        chk("a_rdy_head", in_ready_o, 2'b10);
        tick();
        chk("a_vld_head", out_valid_o, 1);
        chk("a_flit_head", out_flit_o, fl(2'b01, 32'hA1));
        chk("a_busy_head", busy_o, 1);
        in_flit_i[1] = fl(2'b00, 32'hA2);
        grant_i = 2'b00;
        settle();
        chk("a_req_locked", req_o, 2'b00);
        chk("a_rdy_body", in_ready_o, 2'b10);
        tick();
        chk("a_flit_body", out_flit_o, fl(2'b00, 32'hA2));
        chk("a_busy_body", busy_o, 1);
        in_flit_i[1] = fl(2'b10, 32'hA3);
        tick();
        chk("a_flit_tail", out_flit_o, fl(2'b10, 32'hA3));
        chk("a_busy_tail", busy_o, 0);
        in_valid_i = 2'b00;
        tick();
        chk("a_drain", out_valid_o, 0);

        // malformed grants accept nothing
        in_valid_i = 2'b11;
        in_flit_i[0] = fl(2'b01, 32'hD0);
        in_flit_i[1] = fl(2'b01, 32'hD1);
        grant_i = 2'b11;
        settle();
        chk("g11_rdy", in_ready_o, 2'b00);
        grant_i = 2'b00;
        settle();
        chk("g00_rdy", in_ready_o, 2'b00);
        in_valid_i = 2'b01;
        grant_i = 2'b10;
        settle();
        chk("gnoreq_rdy", in_ready_o, 2'b00);
        tick();
        chk("gbad_vld", out_valid_o, 0);
        chk("gbad_busy", busy_o, 0);

        // contention: input 0 wins, input 1 waits
        in_valid_i = 2'b11;
        in_flit_i[0] = fl(2'b01, 32'hB1);
        in_flit_i[1] = fl(2'b01, 32'hC1);
        grant_i = 2'b01;
        settle();
        chk("b_req", req_o, 2'b11);
        chk("b_rdy_head", in_ready_o, 2'b01);
        tick();
        chk("b_flit_head", out_flit_o, fl(2'b01, 32'hB1));
        in_flit_i[0] = fl(2'b00, 32'hB2);
        settle();
        chk("b_rdy_body", in_ready_o, 2'b01);
        tick();
        chk("b_flit_body", out_flit_o, fl(2'b00, 32'hB2));
        in_flit_i[0] = fl(2'b10, 32'hB3);
        settle();
        chk("b_stall1", in_ready_o[1], 0);
        tick();
        chk("b_flit_tail", out_flit_o, fl(2'b10, 32'hB3));
        chk("b_busy_tail", busy_o, 0);
        in_valid_i = 2'b10;
        grant_i = 2'b10;
        settle();
        chk("c_req", req_o, 2'b10);
        chk("c_rdy_head", in_ready_o, 2'b10);
        tick();
        chk("c_flit_head", out_flit_o, fl(2'b01, 32'hC1));
        chk("c_busy", busy_o, 1);

        // backpressure for 3 cycles mid-packet
        in_flit_i[1] = fl(2'b00, 32'hC2);
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("bp_rdy", in_ready_o, 2'b00);
            tick();
            chk("bp_vld", out_valid_o, 1);
            chk("bp_hold", out_flit_o, fl(2'b01, 32'hC1));
        end
        out_ready_i = 1'b1;
        settle();
        chk("bp_release_rdy", in_ready_o, 2'b10);
        tick();
        chk("bp_body", out_flit_o, fl(2'b00, 32'hC2));

        // protocol error: HEAD on the owner while locked
        in_flit_i[1] = fl(2'b01, 32'hC3);
        tick();
        chk("e_err", err_o, 1);
        chk("e_fwd", out_flit_o, fl(2'b01, 32'hC3));
        chk("e_busy", busy_o, 1);
        in_flit_i[1] = fl(2'b10, 32'hC4);
        tick();
        chk("e_tail", out_flit_o, fl(2'b10, 32'hC4));
        chk("e_busy_tail", busy_o, 0);
        chk("e_sticky", err_o, 1);
        in_valid_i = 2'b00;
        tick();
        chk("e_drain", out_valid_o, 0);
        chk("e_sticky2", err_o, 1);

        // HEAD_TAIL on 0 then HEAD on 1 next cycle
        in_valid_i = 2'b01;
        in_flit_i[0] = fl(2'b11, 32'hE1);
        grant_i = 2'b01;
        settle();
        chk("ht_rdy", in_ready_o, 2'b01);
        tick();
        chk("ht_flit", out_flit_o, fl(2'b11, 32'hE1));
        chk("ht_busy", busy_o, 0);
        in_valid_i = 2'b10;
        in_flit_i[1] = fl(2'b01, 32'hF1);
        grant_i = 2'b10;
        settle();
        chk("ht_next_rdy", in_ready_o, 2'b10);
        tick();
        chk("ht_next_flit", out_flit_o, fl(2'b01, 32'hF1));
        chk("ht_next_busy", busy_o, 1);

        // reset mid-packet
        rst = 1'b1;
        settle();
        chk("mrst_rdy", in_ready_o, 2'b00);
        chk("mrst_req", req_o, 2'b00);
        tick();
        chk("mrst_vld", out_valid_o, 0);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_err", err_o, 0);
        rst = 1'b0;
        in_valid_i = 2'b00;
        tick();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/noc_out_port_ctrl.md
NOC_OUT_PORT_CTRL -- requirements
Module: noc_out_port_ctrl

Interface
REQ-001 Parameter FLIT_W, default 34: flit width; bits [FLIT_W-1:FLIT_W-2] carry the flit type, bits [FLIT_W-3:0] carry the payload.
REQ-002 clk  input  1  the single clock; all state SHALL change on its rising edge only.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid_i  input  2  per-input flit valid (index 0 and 1).
REQ-005 in_flit_i  input  2xFLIT_W  per-input flit.
REQ-006 in_ready_o  output  2  per-input flit accepted when valid and ready are both 1.
REQ-007 req_o  output  2  request vector to the upstream 2-input fixed-priority arbiter.
REQ-008 grant_i  input  2  combinational one-hot grant returned by that arbiter.
REQ-009 out_valid_o  output  1  output flit valid.
REQ-010 out_flit_o  output  FLIT_W  output flit.
REQ-011 out_ready_i  input  1  downstream ready.
REQ-012 busy_o  output  1  high while an output lock is held (state LOCKED).
REQ-013 err_o  output  1  sticky protocol-error flag.

Function
REQ-014 Flit types: 2'b01 HEAD, 2'b00 BODY, 2'b10 TAIL, 2'b11 HEAD_TAIL (single-flit packet).
REQ-015 The block SHALL implement a two-state FSM: IDLE and LOCKED. A 1-bit owner register SHALL hold the index of the locked input.
REQ-016 The output SHALL be a single register stage: out_valid_o and out_flit_o SHALL be driven from flops, giving 1-cycle latency from acceptance to output.
REQ-017 Stage free: stage_free = !out_valid_o || out_ready_i. An input flit SHALL be accepted only when stage_free is 1, which sustains one flit per cycle.
REQ-018 IDLE: req_o[k] = in_valid_i[k] and the type of in_flit_i[k] is HEAD or HEAD_TAIL; req_o SHALL be 0 in LOCKED.
REQ-019 IDLE: in_ready_o[k] = grant_i[k] and req_o[k] and stage_free, and grant_i SHALL be onehot.
REQ-020 IDLE acceptance of a HEAD SHALL load the output register, set owner=k, and move to LOCKED; acceptance of a HEAD_TAIL SHALL load the register and stay in IDLE.
REQ-021 IDLE: if grant_i is zero, not one-hot, or selects a non-requesting input, both in_ready_o bits SHALL be 0 and no state SHALL change.
REQ-022 LOCKED: in_ready_o[owner] = stage_free and in_ready_o[!owner] = 0.
REQ-023 LOCKED: an accepted TAIL SHALL return the FSM to IDLE in the same edge; an accepted BODY SHALL keep the FSM in LOCKED.
REQ-024 LOCKED: an accepted HEAD or HEAD_TAIL SHALL set err_o. The flit SHALL still be forwarded and the state SHALL stay LOCKED.
REQ-025 Back-to-back packets: a new HEAD MAY be arbitrated on the cycle after the TAIL was accepted, not the same cycle.
REQ-026 The output register SHALL hold its contents while out_valid_o=1 and out_ready_i=0. out_valid_o SHALL clear when the register is drained with no new acceptance.
REQ-027 busy_o SHALL equal (state == LOCKED).

Reset
REQ-028 On rst=1 at a clock edge: state=IDLE, owner=0, out_valid_o=0, out_flit_o=0, err_o=0.
REQ-029 Reset mid-packet SHALL abandon the lock and drop the buffered flit. in_ready_o and req_o SHALL be 0 during the reset cycle.

Structure
REQ-030 A shared NoC package SHALL hold FLIT_W, the flit-type encodings, and the FSM state enum.
REQ-031 One sub-module, noc_out_reg (the valid/ready output register stage), SHALL be instantiated; the arbiter stays external.

Verification
REQ-032 Reset: assert rst for 2 cycles with in_valid_i=2'b11 -> out_valid_o=0, req_o=0, busy_o=0, err_o=0.
REQ-033 Single packet on input 1: HEAD, BODY, TAIL with grant_i=2'b10 and out_ready_i=1 -> three flits appear in order at out_flit_o one cycle after each acceptance; busy_o is 1 from after HEAD until after TAIL.
REQ-034 Contention: both inputs present a HEAD and the grant is 2'b01 -> the input-0 packet is forwarded whole and input 1 stays stalled (in_ready_o[1]=0). Input 1 is granted the cycle after the input-0 TAIL.
REQ-035 Backpressure: out_ready_i=0 for 3 cycles mid-packet -> out_flit_o is held stable, in_ready_o=0, and no flit is lost or duplicated.
REQ-036 Protocol error: a HEAD is sent on the owner input while LOCKED -> err_o=1 and stays 1 until rst; the flit is still forwarded.
REQ-037 HEAD_TAIL on input 0 followed by a HEAD on input 1 -> busy_o stays 0 after the HEAD_TAIL, and the input-1 HEAD is accepted on the next cycle.
